// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants and types for the register file /
// write-pending scoreboard slice.
//   XLEN_DEF   - default register width
//   REG_NUM    - default architectural register count (x0..x31)
//   REG_ADDR_W - register address width for REG_NUM registers
//   CNT_W_DEF  - default width of each pending-write counter
//   ZERO_WORD  - value returned for x0 and for reset storage
package regfile_sb_pkg;

  localparam int          XLEN_DEF   = 32;
  localparam int          REG_NUM    = 32;
  localparam int          REG_ADDR_W = $clog2(REG_NUM);
  localparam int          CNT_W_DEF  = 2;
  localparam logic [31:0] ZERO_WORD  = 32'h0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]   reg_data_t;

  // Largest count a CNT_W-bit pending counter can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a write to this register was issued this cycle
//   dec        : a write to this register retires this cycle
//   cnt        : current count of outstanding writes
//   ovf / udf  : this cycle's request would wrap the counter; it holds instead
// Simultaneous inc and dec cancel and never flag an error.
module sb_counter import regfile_sb_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic up, dn;

  assign up  = inc && !dec;
  assign dn  = dec && !inc;
  assign ovf = up && (cnt == CMAX);
  assign udf = dn && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (up && !ovf)    cnt <= cnt + ONE;
    else if (dn && !udf)    cnt <= cnt - ONE;
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with write-to-read bypass and a
// per-register write-pending scoreboard for decode hazard detection.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rs1/rs2_addr_i        : decode read addresses
//   rs1/rs2_data_o        : read data (combinational, bypassed, x0 = 0)
//   rs1/rs2_busy_o        : operand still has an unretired pending write
//   issue_en_i/issue_rd_i : decode issues an instruction that writes rd
//   wb_wen_i/wb_rd_i/wb_data_i : single writeback port
//   err_o                 : sticky scoreboard overflow/underflow
module regfile_sb import regfile_sb_pkg::*; #(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREG  = REG_NUM,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic            issue_en_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            wb_wen_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            err_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] rd;
  } issue_req_t;

  wb_req_t    wb;
  issue_req_t iss;

  assign wb  = '{wen: wb_wen_i, rd: wb_rd_i, data: wb_data_i};
  assign iss = '{en: issue_en_i, rd: issue_rd_i};

  // Entry 0 of every array is tied off so x0 reads 0, is never busy and
  // never reaches a counter, without special-casing it in the read path.
  logic [NREG-1:0][XLEN-1:0]  regs;
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc, dec, ovf, udf;

  assign regs[0] = '0;
  assign cnt[0]  = '0;
  assign inc[0]  = 1'b0;
  assign dec[0]  = 1'b0;
  assign ovf[0]  = 1'b0;
  assign udf[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    localparam logic [AW-1:0] RA = AW'(r);
    logic [XLEN-1:0] q;

    assign inc[r] = iss.en && (iss.rd == RA);
    assign dec[r] = wb.wen && (wb.rd == RA);

    // The data write happens even on scoreboard underflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q <= '0;
      else if (dec[r]) q <= wb.data;
    end

    assign regs[r] = q;

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .cnt   (cnt[r]),
      .ovf   (ovf[r]),
      .udf   (udf[r])
    );
  end

  // Read data: x0 -> 0, else bypass a same-cycle writeback, else storage.
  always_comb begin
    rs1_data_o = regs[rs1_addr_i];
    if (dec[rs1_addr_i]) rs1_data_o = wb.data;
    rs2_data_o = regs[rs2_addr_i];
    if (dec[rs2_addr_i]) rs2_data_o = wb.data;
  end

  // Busy drops in the cycle the last pending write retires, because the
  // bypass already delivers that value. A same-cycle re-issue keeps it busy.
  always_comb begin
    rs1_busy_o = (cnt[rs1_addr_i] != '0) &&
                 !(dec[rs1_addr_i] && (cnt[rs1_addr_i] == ONE) && !inc[rs1_addr_i]);
    rs2_busy_o = (cnt[rs2_addr_i] != '0) &&
                 !(dec[rs2_addr_i] && (cnt[rs2_addr_i] == ONE) && !inc[rs2_addr_i]);
  end

  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_q <= 1'b0;
    else if (|{ovf, udf}) err_q <= 1'b1;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, wb_rd_i;
  logic [31:0] rs1_data_o, rs2_data_o, wb_data_i;
  logic        rs1_busy_o, rs2_busy_o, issue_en_i, wb_wen_i, err_o;

  regfile_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .rs1_busy_o (rs1_busy_o),
    .rs2_busy_o (rs2_busy_o),
    .issue_en_i (issue_en_i),
    .issue_rd_i (issue_rd_i),
    .wb_wen_i   (wb_wen_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r1, r2;
    logic        ie;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] d1, d2;
    logic        b1, b2, e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic stim_t mk(input logic [4:0] r1, input logic [4:0] r2,
                               input logic ie, input logic [4:0] ird,
                               input logic we, input logic [4:0] wrd,
                               input logic [31:0] wd);
    stim_t s;
    s.r1 = r1; s.r2 = r2; s.ie = ie; s.ird = ird; s.we = we; s.wrd = wrd; s.wd = wd;
    return s;
  endfunction

  function automatic exp_t ex(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                              input logic b1, input logic b2, input logic e);
    exp_t x;
    x.tag = tag; x.d1 = d1; x.d2 = d2; x.b1 = b1; x.b2 = b2; x.e = e;
    return x;
  endfunction

  // Drive one cycle of stimulus at the falling edge (inputs only).
  task automatic apply(input stim_t s);
    @(negedge clk);
    rs1_addr_i = s.r1; rs2_addr_i = s.r2;
    issue_en_i = s.ie; issue_rd_i = s.ird;
    wb_wen_i   = s.we; wb_rd_i    = s.wrd; wb_data_i = s.wd;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    apply(mk(5, 0, 0, 0, 0, 0, 0));
    sb.push_back(ex("reset_hold", 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); total++;
    if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
      bad++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
               e.tag, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
    end
    apply(mk(5, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    sb.push_back(ex("reset_release", 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); total++;
    if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
      bad++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
               e.tag, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
    end
  endtask

  // Runs a stimulus/expectation table one cycle per entry.
  task automatic test_table(input stim_t s[$], input exp_t x[$]);
    exp_t e;
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      sb.push_back(x[i]);
      #1;
      e = sb.pop_front(); total++;
      if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
        bad++;
        $display("FAIL %s[%0d]: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
                 e.tag, i, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
      end
    end
  endtask

  task automatic test_raw();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(5, 0, 1, 5, 0, 0, 0));             x.push_back(ex("raw_issue", 0, 0, 0, 0, 0));
    s.push_back(mk(5, 0, 0, 0, 0, 0, 0));             x.push_back(ex("raw_wait", 0, 0, 1, 0, 0));
    s.push_back(mk(5, 0, 0, 0, 1, 5, 32'hDEADBEEF));  x.push_back(ex("raw_bypass", 32'hDEADBEEF, 0, 0, 0, 0));
    s.push_back(mk(5, 0, 0, 0, 0, 0, 0));             x.push_back(ex("raw_storage", 32'hDEADBEEF, 0, 0, 0, 0));
    test_table(s, x);
  endtask

  task automatic test_multi_pending();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(0, 7, 1, 7, 0, 0, 0));        x.push_back(ex("multi_iss1", 0, 0, 0, 0, 0));
    s.push_back(mk(0, 7, 1, 7, 0, 0, 0));        x.push_back(ex("multi_iss2", 0, 0, 0, 1, 0));
    s.push_back(mk(0, 7, 0, 0, 0, 0, 0));        x.push_back(ex("multi_cnt2", 0, 0, 0, 1, 0));
    s.push_back(mk(0, 7, 0, 0, 1, 7, 32'h77));   x.push_back(ex("multi_wb1", 0, 32'h77, 0, 1, 0));
    s.push_back(mk(0, 7, 0, 0, 0, 0, 0));        x.push_back(ex("multi_cnt1", 0, 32'h77, 0, 1, 0));
    s.push_back(mk(0, 7, 0, 0, 1, 7, 32'h78));   x.push_back(ex("multi_wb2", 0, 32'h78, 0, 0, 0));
    s.push_back(mk(0, 7, 0, 0, 0, 0, 0));        x.push_back(ex("multi_idle", 0, 32'h78, 0, 0, 0));
    test_table(s, x);
  endtask

  task automatic test_same_cycle();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(3, 0, 1, 3, 0, 0, 0));        x.push_back(ex("same_iss", 0, 0, 0, 0, 0));
    s.push_back(mk(3, 0, 1, 3, 1, 3, 32'h11));   x.push_back(ex("same_both", 32'h11, 0, 1, 0, 0));
    s.push_back(mk(3, 0, 0, 0, 0, 0, 0));        x.push_back(ex("same_cnt1", 32'h11, 0, 1, 0, 0));
    s.push_back(mk(3, 0, 0, 0, 1, 3, 32'h12));   x.push_back(ex("same_wb", 32'h12, 0, 0, 0, 0));
    s.push_back(mk(3, 0, 0, 0, 0, 0, 0));        x.push_back(ex("same_idle", 32'h12, 0, 0, 0, 0));
    test_table(s, x);
  endtask

  task automatic test_x0();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(0, 5, 1, 0, 1, 0, 32'hFFFFFFFF)); x.push_back(ex("x0_write", 0, 32'hDEADBEEF, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0));            x.push_back(ex("x0_after", 0, 0, 0, 0, 0));
    test_table(s, x);
  endtask

  task automatic test_overflow();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(9, 0, 1, 9, 0, 0, 0));        x.push_back(ex("ovf_iss1", 0, 0, 0, 0, 0));
    s.push_back(mk(9, 0, 1, 9, 0, 0, 0));        x.push_back(ex("ovf_iss2", 0, 0, 1, 0, 0));
    s.push_back(mk(9, 0, 1, 9, 0, 0, 0));        x.push_back(ex("ovf_iss3", 0, 0, 1, 0, 0));
    s.push_back(mk(9, 0, 1, 9, 0, 0, 0));        x.push_back(ex("ovf_iss4", 0, 0, 1, 0, 0));
    s.push_back(mk(9, 0, 0, 0, 0, 0, 0));        x.push_back(ex("ovf_err", 0, 0, 1, 0, 1));
    s.push_back(mk(9, 0, 0, 0, 1, 9, 32'h90));   x.push_back(ex("ovf_wb1", 32'h90, 0, 1, 0, 1));
    s.push_back(mk(9, 0, 0, 0, 1, 9, 32'h91));   x.push_back(ex("ovf_wb2", 32'h91, 0, 1, 0, 1));
    s.push_back(mk(9, 0, 0, 0, 1, 9, 32'h92));   x.push_back(ex("ovf_wb3", 32'h92, 0, 0, 0, 1));
    s.push_back(mk(9, 0, 0, 0, 0, 0, 0));        x.push_back(ex("ovf_drain", 32'h92, 0, 0, 0, 1));
    test_table(s, x);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(11, 9, 1, 11, 0, 0, 0));      x.push_back(ex("rst_pre_iss", 0, 32'h92, 0, 0, 1));
    s.push_back(mk(11, 9, 0, 0, 0, 0, 0));       x.push_back(ex("rst_pre_busy", 0, 32'h92, 1, 0, 1));
    test_table(s, x);
    // Reset asserted between clock edges must clear everything at once.
    apply(mk(11, 9, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    sb.push_back(ex("rst_async", 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); total++;
    if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
      bad++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
               e.tag, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
    end
    // Bypass stays live in reset; the write and issue must not land.
    apply(mk(9, 5, 1, 11, 1, 5, 32'hAB));
    sb.push_back(ex("rst_bypass", 0, 32'hAB, 0, 0, 0));
    #1;
    e = sb.pop_front(); total++;
    if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
      bad++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
               e.tag, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
    end
    apply(mk(5, 11, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    sb.push_back(ex("rst_ignored", 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); total++;
    if ({rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o} !== {e.d1, e.d2, e.b1, e.b2, e.e}) begin
      bad++;
      $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b err=%b want d1=%h d2=%h b1=%b b2=%b err=%b",
               e.tag, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o, e.d1, e.d2, e.b1, e.b2, e.e);
    end
  endtask

  task automatic test_underflow();
    stim_t s[$]; exp_t x[$];
    s.push_back(mk(12, 0, 0, 0, 1, 12, 32'h55)); x.push_back(ex("udf_wb", 32'h55, 0, 0, 0, 0));
    s.push_back(mk(12, 0, 0, 0, 0, 0, 0));       x.push_back(ex("udf_err", 32'h55, 0, 0, 0, 1));
    test_table(s, x);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr_i = '0; rs2_addr_i = '0;
    issue_en_i = 1'b0; issue_rd_i = '0;
    wb_wen_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    test_reset();
    test_raw();
    test_multi_pending();
    test_same_cycle();
    test_x0();
    test_overflow();
    test_reset_mid();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
